// File: rtl/bsr_stream_unpacker_if.sv
// Bus bundle between the BSR stream unpacker and its surroundings: the
// first-word-fall-through DMA FIFO read side and the three on-chip buffer
// write ports (row_ptr, col_idx, block payload).
//   master: the unpacker (pops the FIFO, drives buffer writes)
//   slave : the FIFO and buffer side
interface bsr_stream_unpacker_if #(
    parameter int unsigned ROW_AW = 9,
    parameter int unsigned COL_AW = 12,
    parameter int unsigned BLK_AW = 16
) ();
    logic [31:0]       fifo_rdata;
    logic              fifo_empty;
    logic              fifo_ren;
    logic              rowptr_we;
    logic [ROW_AW-1:0] rowptr_addr;
    logic [31:0]       rowptr_wdata;
    logic              colidx_we;
    logic [COL_AW-1:0] colidx_addr;
    logic [15:0]       colidx_wdata;
    logic              blk_we;
    logic [BLK_AW-1:0] blk_addr;
    logic [31:0]       blk_wdata;

    modport master (
        input  fifo_rdata, fifo_empty,
        output fifo_ren,
        output rowptr_we, rowptr_addr, rowptr_wdata,
        output colidx_we, colidx_addr, colidx_wdata,
        output blk_we, blk_addr, blk_wdata
    );

    modport slave (
        output fifo_rdata, fifo_empty,
        input  fifo_ren,
        input  rowptr_we, rowptr_addr, rowptr_wdata,
        input  colidx_we, colidx_addr, colidx_wdata,
        input  blk_we, blk_addr, blk_wdata
    );
endinterface

// File: rtl/bsr_stream_unpacker.sv
// Drains the 32-bit DMA word FIFO and parses a block-sparse-row stream
// (two header words, row_ptr, packed col_idx pairs, block payload) into the
// on-chip buffers read by the systolic array.
// Ports:
//   clk, rst (synchronous, active high), start (1-cycle arm pulse)
//   bus      : FIFO read side + row_ptr/col_idx/block write ports (master)
//   num_rows, num_blocks : latched header fields
//   busy, done, error, err_code : status toward the CSR block
// Optional feature: define BSR_UNPACK_CHECK_EN to validate each row_ptr word
// before it is written (err_code 3 on failure).
module bsr_stream_unpacker #(
    parameter int unsigned MAX_ROWS    = 256,
    parameter int unsigned MAX_BLOCKS  = 4096,
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned ROW_AW      = 9,
    parameter int unsigned COL_AW      = 12,
    parameter int unsigned BLK_AW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bsr_stream_unpacker_if.master bus,
    output logic [15:0]          num_rows,
    output logic [15:0]          num_blocks,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);
    localparam logic [7:0] MAGIC = 8'hB5;

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, ROWPTR, COLIDX, COL_HI, BLOCKS, DONE, ERR
    } state_t;

    state_t state, state_d;

    logic [ROW_AW-1:0] row_idx, row_idx_d;
    logic [COL_AW-1:0] col_idx, col_idx_d;
    logic [BLK_AW-1:0] blk_idx, blk_idx_d;
    logic [15:0]       col_hi, col_hi_d;

    logic              rowptr_we, rowptr_we_d;
    logic [ROW_AW-1:0] rowptr_addr, rowptr_addr_d;
    logic [31:0]       rowptr_wdata, rowptr_wdata_d;
    logic              colidx_we, colidx_we_d;
    logic [COL_AW-1:0] colidx_addr, colidx_addr_d;
    logic [15:0]       colidx_wdata, colidx_wdata_d;
    logic              blk_we, blk_we_d;
    logic [BLK_AW-1:0] blk_addr, blk_addr_d;
    logic [31:0]       blk_wdata, blk_wdata_d;

    logic [15:0] num_rows_d, num_blocks_d;
    logic        busy_d, done_d, error_d;
    logic [1:0]  err_code_d;

    logic        pop_c;
    logic        rp_bad_c;
    logic        row_last_c;
    logic        blk_last_c;
    logic [15:0] col_rem_c;
    logic [31:0] blk_total_m1_c;

    assign bus.fifo_ren     = pop_c;
    assign bus.rowptr_we    = rowptr_we;
    assign bus.rowptr_addr  = rowptr_addr;
    assign bus.rowptr_wdata = rowptr_wdata;
    assign bus.colidx_we    = colidx_we;
    assign bus.colidx_addr  = colidx_addr;
    assign bus.colidx_wdata = colidx_wdata;
    assign bus.blk_we       = blk_we;
    assign bus.blk_addr     = blk_addr;
    assign bus.blk_wdata    = blk_wdata;

    // Progress markers for the variable-length sections.
    assign row_last_c     = (16'(row_idx) == num_rows);
    assign col_rem_c      = num_blocks - 16'(col_idx);
    assign blk_total_m1_c = 32'(num_blocks) * 32'(BLOCK_WORDS) - 32'd1;
    assign blk_last_c     = (32'(blk_idx) == blk_total_m1_c);

`ifdef BSR_UNPACK_CHECK_EN
    logic [31:0] rp_prev;

    // Previous accepted row_ptr value for the monotonicity check.
    always_ff @(posedge clk) begin
        if (rst) begin
            rp_prev <= '0;
        end else if (pop_c && state == ROWPTR) begin
            rp_prev <= bus.fifo_rdata;
        end
    end

    assign rp_bad_c = ((row_idx == '0) && (bus.fifo_rdata != 32'd0))
                   || ((row_idx != '0) && (bus.fifo_rdata < rp_prev))
                   || (row_last_c && (bus.fifo_rdata != 32'(num_blocks)));
`else
    assign rp_bad_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            row_idx      <= '0;
            col_idx      <= '0;
            blk_idx      <= '0;
            col_hi       <= '0;
            rowptr_we    <= 1'b0;
            rowptr_addr  <= '0;
            rowptr_wdata <= '0;
            colidx_we    <= 1'b0;
            colidx_addr  <= '0;
            colidx_wdata <= '0;
            blk_we       <= 1'b0;
            blk_addr     <= '0;
            blk_wdata    <= '0;
            num_rows     <= '0;
            num_blocks   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= '0;
        end else begin
            state        <= state_d;
            row_idx      <= row_idx_d;
            col_idx      <= col_idx_d;
            blk_idx      <= blk_idx_d;
            col_hi       <= col_hi_d;
            rowptr_we    <= rowptr_we_d;
            rowptr_addr  <= rowptr_addr_d;
            rowptr_wdata <= rowptr_wdata_d;
            colidx_we    <= colidx_we_d;
            colidx_addr  <= colidx_addr_d;
            colidx_wdata <= colidx_wdata_d;
            blk_we       <= blk_we_d;
            blk_addr     <= blk_addr_d;
            blk_wdata    <= blk_wdata_d;
            num_rows     <= num_rows_d;
            num_blocks   <= num_blocks_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            err_code     <= err_code_d;
        end
    end

    // Next-state, pop and buffer-write decode.
    always_comb begin
        state_d        = state;
        pop_c          = 1'b0;
        row_idx_d      = row_idx;
        col_idx_d      = col_idx;
        blk_idx_d      = blk_idx;
        col_hi_d       = col_hi;
        rowptr_we_d    = 1'b0;
        rowptr_addr_d  = rowptr_addr;
        rowptr_wdata_d = rowptr_wdata;
        colidx_we_d    = 1'b0;
        colidx_addr_d  = colidx_addr;
        colidx_wdata_d = colidx_wdata;
        blk_we_d       = 1'b0;
        blk_addr_d     = blk_addr;
        blk_wdata_d    = blk_wdata;
        num_rows_d     = num_rows;
        num_blocks_d   = num_blocks;
        done_d         = done;
        error_d        = error;
        err_code_d     = err_code;

        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR0;
                    row_idx_d  = '0;
                    col_idx_d  = '0;
                    blk_idx_d  = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                end
            end
            HDR0: begin
                if (!bus.fifo_empty) begin
                    pop_c      = 1'b1;
                    num_rows_d = bus.fifo_rdata[15:0];
                    if (bus.fifo_rdata[31:24] != MAGIC) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd0;
                    end else begin
                        state_d = HDR1;
                    end
                end
            end
            HDR1: begin
                if (!bus.fifo_empty) begin
                    pop_c        = 1'b1;
                    num_blocks_d = bus.fifo_rdata[15:0];
                    if (num_rows == 16'd0 || num_rows > 16'(MAX_ROWS)) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end else if (bus.fifo_rdata[15:0] > 16'(MAX_BLOCKS)) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                    end else begin
                        state_d = ROWPTR;
                    end
                end
            end
            ROWPTR: begin
                if (!bus.fifo_empty) begin
                    pop_c = 1'b1;
                    if (rp_bad_c) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                    end else begin
                        rowptr_we_d    = 1'b1;
                        rowptr_addr_d  = row_idx;
                        rowptr_wdata_d = bus.fifo_rdata;
                        row_idx_d      = row_idx + 1'b1;
                        if (row_last_c) begin
                            if (num_blocks == 16'd0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = COLIDX;
                            end
                        end
                    end
                end
            end
            COLIDX: begin
                // Low half written now; the high half is held for the
                // following cycle unless this word is an odd tail.
                if (!bus.fifo_empty) begin
                    pop_c          = 1'b1;
                    colidx_we_d    = 1'b1;
                    colidx_addr_d  = col_idx;
                    colidx_wdata_d = bus.fifo_rdata[15:0];
                    col_hi_d       = bus.fifo_rdata[31:16];
                    col_idx_d      = col_idx + 1'b1;
                    state_d        = (col_rem_c == 16'd1) ? BLOCKS : COL_HI;
                end
            end
            COL_HI: begin
                colidx_we_d    = 1'b1;
                colidx_addr_d  = col_idx;
                colidx_wdata_d = col_hi;
                col_idx_d      = col_idx + 1'b1;
                state_d        = (col_rem_c == 16'd1) ? BLOCKS : COLIDX;
            end
            BLOCKS: begin
                if (!bus.fifo_empty) begin
                    pop_c       = 1'b1;
                    blk_we_d    = 1'b1;
                    blk_addr_d  = blk_idx;
                    blk_wdata_d = bus.fifo_rdata;
                    blk_idx_d   = blk_idx + 1'b1;
                    if (blk_last_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = !(state_d == IDLE || state_d == DONE || state_d == ERR);
    end
endmodule

// File: tb/tb_bsr_stream_unpacker.sv
// Self-checking bench for bsr_stream_unpacker: a queue-based FIFO feeds
// directed and random streams; a stream-level reference model derives the
// expected buffer writes, pop count and final status.
module tb_bsr_stream_unpacker;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_rows;
    logic [15:0] num_blocks;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    bsr_stream_unpacker_if #(.ROW_AW(9), .COL_AW(12), .BLK_AW(16)) bus ();

    bsr_stream_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.master),
        .num_rows   (num_rows),
        .num_blocks (num_blocks),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] strm[$];
    logic [31:0] fifo_q[$];
    logic [63:0] obs_rp[$], obs_ci[$], obs_blk[$];
    logic [63:0] exp_rp[$], exp_ci[$], exp_blk[$];
    bit          exp_done, exp_err;
    logic [1:0]  exp_code;
    int          exp_pops;
    bit          s_busy, s_done, s_error;
    int          ren_bad;
    int          pop_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: sample registered outputs, drive inputs, commit the pop.
    task automatic step(input bit st, input bit rs, input bit bub);
        bit pop;
        @(negedge clk);
        s_busy  = busy;
        s_done  = done;
        s_error = error;
        if (bus.rowptr_we) obs_rp.push_back({32'(bus.rowptr_addr), bus.rowptr_wdata});
        if (bus.colidx_we) obs_ci.push_back({32'(bus.colidx_addr), 32'(bus.colidx_wdata)});
        if (bus.blk_we)    obs_blk.push_back({32'(bus.blk_addr), bus.blk_wdata});
        start = st;
        rst   = rs;
        bus.fifo_empty = (fifo_q.size() == 0) || (bub && $urandom_range(0, 1) == 1);
        bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        #1;
        pop = bus.fifo_ren;
        if (pop && bus.fifo_empty) ren_bad++;
        if (pop) pop_cnt++;
        @(posedge clk);
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    endtask

    // Reference model: walks the stream by its field layout.
    task automatic build_model();
        int nr, nb, p;
        logic [31:0] w, prev;
        exp_rp.delete(); exp_ci.delete(); exp_blk.delete();
        exp_done = 0; exp_err = 0; exp_code = 2'd0; prev = 32'd0;
        w = strm[0];
        exp_pops = 1;
        if (w[31:24] != 8'hB5) begin exp_err = 1; exp_code = 2'd0; return; end
        nr = int'(w[15:0]);
        w  = strm[1];
        nb = int'(w[15:0]);
        exp_pops = 2;
        if (nr == 0 || nr > 256) begin exp_err = 1; exp_code = 2'd1; return; end
        if (nb > 4096) begin exp_err = 1; exp_code = 2'd2; return; end
        for (int i = 0; i <= nr; i++) begin
            w = strm[2 + i];
            exp_pops++;
`ifdef BSR_UNPACK_CHECK_EN
            if ((i == 0 && w != 0) || (i > 0 && w < prev) || (i == nr && w != 32'(nb))) begin
                exp_err = 1; exp_code = 2'd3; return;
            end
`endif
            exp_rp.push_back({32'(i), w});
            prev = w;
        end
        if (nb == 0) begin exp_done = 1; return; end
        p = 3 + nr;
        for (int j = 0; j < nb; j++) begin
            w = strm[p + j / 2];
            exp_ci.push_back({32'(j), 32'((j % 2 == 1) ? w[31:16] : w[15:0])});
        end
        exp_pops += (nb + 1) / 2;
        p += (nb + 1) / 2;
        for (int k = 0; k < nb * 16; k++) exp_blk.push_back({32'(k), strm[p + k]});
        exp_pops += nb * 16;
        exp_done = 1;
    endtask

    task automatic check_result(input string tag, input int busy_low);
        chk({tag, " done"}, 64'(done), 64'(exp_done));
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " err_code"}, 64'(err_code), 64'(exp_code));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " busy_low"}, 64'(busy_low), 64'd0);
        chk({tag, " pops"}, 64'(strm.size() - fifo_q.size()), 64'(exp_pops));
        chk({tag, " ren_empty"}, 64'(ren_bad), 64'd0);
        chk({tag, " rp_n"}, 64'(obs_rp.size()), 64'(exp_rp.size()));
        chk({tag, " ci_n"}, 64'(obs_ci.size()), 64'(exp_ci.size()));
        chk({tag, " blk_n"}, 64'(obs_blk.size()), 64'(exp_blk.size()));
        for (int i = 0; i < exp_rp.size() && i < obs_rp.size(); i++)
            chk($sformatf("%s rp[%0d]", tag, i), obs_rp[i], exp_rp[i]);
        for (int i = 0; i < exp_ci.size() && i < obs_ci.size(); i++)
            chk($sformatf("%s ci[%0d]", tag, i), obs_ci[i], exp_ci[i]);
        for (int i = 0; i < exp_blk.size() && i < obs_blk.size(); i++)
            chk($sformatf("%s blk[%0d]", tag, i), obs_blk[i], exp_blk[i]);
    endtask

    task automatic run_stream(input string tag, input bit bub, input int restart_at);
        int n, busy_low;
        fifo_q = strm;
        obs_rp.delete(); obs_ci.delete(); obs_blk.delete();
        ren_bad = 0;
        build_model();
        step(1, 0, bub);
        n = 0;
        busy_low = 0;
        do begin
            step(n == restart_at, 0, bub);
            n++;
            if (!s_done && !s_error && !s_busy) busy_low++;
        end while (!s_done && !s_error && n < 3000);
        chk({tag, " timeout"}, 64'(n < 3000), 64'd1);
        pop_cnt = 0;
        repeat (4) step(0, 0, bub);
        chk({tag, " ren_after_end"}, 64'(pop_cnt), 64'd0);
        check_result(tag, busy_low);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " error"}, 64'(error), 64'd0);
        chk({tag, " err_code"}, 64'(err_code), 64'd0);
        chk({tag, " num_rows"}, 64'(num_rows), 64'd0);
        chk({tag, " num_blocks"}, 64'(num_blocks), 64'd0);
        chk({tag, " fifo_ren"}, 64'(bus.fifo_ren), 64'd0);
        chk({tag, " rowptr_we"}, 64'(bus.rowptr_we), 64'd0);
        chk({tag, " colidx_we"}, 64'(bus.colidx_we), 64'd0);
        chk({tag, " blk_we"}, 64'(bus.blk_we), 64'd0);
        chk({tag, " blk_addr"}, 64'(bus.blk_addr), 64'd0);
    endtask

    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) strm.push_back($urandom);
    endtask

    task automatic make_nominal();
        strm = '{32'hB500_0002, 32'h0000_0003, 32'd0, 32'd2, 32'd3,
                 32'h0004_0001, 32'h0000_0007};
        push_payload(48);
    endtask

    // Random legal stream with a monotonic row_ptr ending at num_blocks.
    task automatic make_random();
        int nr, nb, r;
        nr = $urandom_range(1, 4);
        nb = $urandom_range(0, 7);
        strm = '{};
        strm.push_back({8'hB5, 8'h00, 16'(nr)});
        strm.push_back(32'(nb));
        r = 0;
        strm.push_back(32'd0);
        for (int i = 1; i < nr; i++) begin
            r = r + $urandom_range(0, nb - r);
            strm.push_back(32'(r));
        end
        strm.push_back(32'(nb));
        for (int j = 0; j < (nb + 1) / 2; j++) strm.push_back($urandom);
        push_payload(nb * 16);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 32'h0;
        ren_bad = 0;
        pop_cnt = 0;
        repeat (3) step(0, 1, 0);
        @(negedge clk);
        chk_zero("reset");
        step(0, 0, 0);

        make_nominal();
        run_stream("nominal", 0, -1);
        chk("nominal num_rows", 64'(num_rows), 64'd2);
        chk("nominal num_blocks", 64'(num_blocks), 64'd3);

        make_nominal();
        run_stream("bubbles", 1, -1);

        make_nominal();
        run_stream("start_busy", 0, 10);

        strm = '{32'hA500_0002, 32'h0000_0003, 32'd0, 32'd2, 32'd3};
        run_stream("bad_magic", 0, -1);

        strm = '{32'hB500_0101, 32'h0000_0003, 32'd0};
        run_stream("rows_257", 0, -1);

        strm = '{32'hB500_0002, 32'h0000_1001, 32'd0};
        run_stream("blocks_4097", 0, -1);

        strm = '{32'hB500_0001, 32'h0000_0000, 32'd0, 32'd0};
        run_stream("zero_blocks", 0, -1);

        strm = '{32'hB500_0002, 32'h0000_0002, 32'd0, 32'd3, 32'd2, 32'h0009_0005};
        push_payload(32);
        run_stream("rp_check", 0, -1);

        for (int t = 0; t < 4; t++) begin
            make_random();
            run_stream($sformatf("random%0d", t), 1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of the payload section.
        make_nominal();
        fifo_q = strm;
        obs_blk.delete();
        step(1, 0, 0);
        n = 0;
        do begin
            step(0, 0, 0);
            n++;
        end while (obs_blk.size() < 5 && n < 500);
        chk("mid_rst reached_blocks", 64'(n < 500), 64'd1);
        step(0, 1, 0);
        @(negedge clk);
        chk_zero("mid_rst");
        step(0, 0, 0);
        fifo_q.delete();
        make_random();
        run_stream("after_rst", 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
